// File: rtl/rollback_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rollback_ctrl_pkg
// Shared ROB header package: ROB geometry constants, the ROB entry layout and
// the rollback controller state encoding.
// -----------------------------------------------------------------------------
package rollback_ctrl_pkg;

    localparam int NUM_ROB = 32;   // ROB entries (power of two)
    localparam int NUM_BR  = 2;    // branch-resolution requesters

    // Rollback controller FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        DRAIN   = 2'd2,
        RECOVER = 2'd3
    } ROLLBACK_STATE_t;

    // One ROB entry as seen by the rest of the core
    typedef struct packed {
        logic        valid;
        logic        done;
        logic        is_branch;
        logic        mispredict;
        logic [31:0] pc;
    } ROB_t;

endpackage

// File: rtl/rollback_ctrl_age_arbiter.sv
// -----------------------------------------------------------------------------
// age_arbiter
// Combinational oldest-of-NUM_BR selector. Age of a ROB index is its distance
// from the current head (modular), so a smaller age is an older instruction.
// Ties resolve to the lowest requester number.
//
// Ports
//   cand        in   per-requester candidate flag (valid & mispredict)
//   rob_idx     in   per-requester ROB index
//   head_idx    in   current ROB head
//   age         out  per-requester age relative to head_idx
//   win_valid   out  at least one candidate present
//   win_sel     out  winning requester number
//   win_rob_idx out  ROB index of the winning requester
// -----------------------------------------------------------------------------
module age_arbiter #(
    parameter int NUM_ROB = rollback_ctrl_pkg::NUM_ROB,
    parameter int NUM_BR  = rollback_ctrl_pkg::NUM_BR,
    localparam int IDX_W  = $clog2(NUM_ROB),
    localparam int SEL_W  = (NUM_BR > 1) ? $clog2(NUM_BR) : 1
) (
    input  logic [NUM_BR-1:0]            cand,
    input  logic [NUM_BR-1:0][IDX_W-1:0] rob_idx,
    input  logic [IDX_W-1:0]             head_idx,
    output logic [NUM_BR-1:0][IDX_W-1:0] age,
    output logic                         win_valid,
    output logic [SEL_W-1:0]             win_sel,
    output logic [IDX_W-1:0]             win_rob_idx
);

    // IDX_W-bit subtraction wraps naturally, giving the modular age
    generate
        for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_age
            assign age[gi] = rob_idx[gi] - head_idx;
        end
    endgenerate

    logic [IDX_W-1:0] best_age;

    // Strict less-than keeps the lower requester on equal ages
    always_comb begin
        win_valid   = 1'b0;
        win_sel     = '0;
        win_rob_idx = '0;
        best_age    = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (cand[i] && (!win_valid || (age[i] < best_age))) begin
                win_valid   = 1'b1;
                win_sel     = SEL_W'(i);
                win_rob_idx = rob_idx[i];
                best_age    = age[i];
            end
        end
    end

endmodule

// File: rtl/rollback_ctrl.sv
// -----------------------------------------------------------------------------
// rollback_ctrl
// Picks the oldest mispredicted branch, pulses a rollback to the ROB, then
// stalls dispatch until the ROB head reaches the branch plus RECOVER_CYC
// recovery cycles. An older mispredict arriving while draining/recovering
// restarts the rollback at the older branch.
//
// Ports
//   clock            in   sole clock, rising edge
//   reset            in   synchronous active-high reset (wins over en)
//   en               in   global enable; low freezes all state
//   br_valid         in   [NUM_BR] branch resolved this cycle
//   br_mispredict    in   [NUM_BR] resolved branch mispredicted
//   br_rob_idx       in   [NUM_BR][log2 NUM_ROB] ROB index per branch
//   rob_head_idx     in   current ROB head
//   rollback_en      out  one-cycle rollback pulse (FLUSH state)
//   ROB_rollback_idx out  held branch index
//   dispatch_stall   out  high whenever not IDLE
//   br_ack           out  [NUM_BR] request consumed (= br_valid when enabled)
//   busy             out  state != IDLE
// -----------------------------------------------------------------------------
module rollback_ctrl #(
    parameter int NUM_ROB     = rollback_ctrl_pkg::NUM_ROB,
    parameter int NUM_BR      = rollback_ctrl_pkg::NUM_BR,
    parameter int RECOVER_CYC = 2,
    localparam int IDX_W      = $clog2(NUM_ROB),
    localparam int SEL_W      = (NUM_BR > 1) ? $clog2(NUM_BR) : 1,
    localparam int CNT_W      = $clog2(RECOVER_CYC + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_BR-1:0]            br_valid,
    input  logic [NUM_BR-1:0]            br_mispredict,
    input  logic [NUM_BR-1:0][IDX_W-1:0] br_rob_idx,
    input  logic [IDX_W-1:0]             rob_head_idx,
    output logic                         rollback_en,
    output logic [IDX_W-1:0]             ROB_rollback_idx,
    output logic                         dispatch_stall,
    output logic [NUM_BR-1:0]            br_ack,
    output logic                         busy
);

    import rollback_ctrl_pkg::*;

    ROLLBACK_STATE_t state_q, state_d;
    logic [IDX_W-1:0] held_idx_q, held_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_BR-1:0]            cand;
    logic [NUM_BR-1:0][IDX_W-1:0] cand_age;
    logic                         win_valid;
    logic [SEL_W-1:0]             win_sel;
    logic [IDX_W-1:0]             win_rob_idx;
    logic [IDX_W-1:0]             win_age;
    logic [IDX_W-1:0]             held_age;
    logic                         win_older;

    assign cand = br_valid & br_mispredict;

    age_arbiter #(
        .NUM_ROB (NUM_ROB),
        .NUM_BR  (NUM_BR)
    ) u_age_arbiter (
        .cand        (cand),
        .rob_idx     (br_rob_idx),
        .head_idx    (rob_head_idx),
        .age         (cand_age),
        .win_valid   (win_valid),
        .win_sel     (win_sel),
        .win_rob_idx (win_rob_idx)
    );

    // Both ages are measured from the current head, so a moving head keeps
    // the comparison consistent across the wrap.
    assign win_age   = cand_age[win_sel];
    assign held_age  = held_idx_q - rob_head_idx;
    assign win_older = win_valid && (win_age < held_age);

    always_comb begin
        state_d    = state_q;
        held_idx_d = held_idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    held_idx_d = win_rob_idx;
                    state_d    = FLUSH;
                end
            end
            // New candidates are ignored here: the pulse already squashes
            // everything younger than the held branch.
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (win_older) begin
                    held_idx_d = win_rob_idx;
                    state_d    = FLUSH;
                end else if (rob_head_idx == held_idx_q) begin
                    cnt_d   = CNT_W'(RECOVER_CYC - 1);
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                if (win_older) begin
                    held_idx_d = win_rob_idx;
                    state_d    = FLUSH;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            held_idx_q <= '0;
            cnt_q      <= '0;
        end else if (en) begin
            state_q    <= state_d;
            held_idx_q <= held_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decode the registered state; the pulse and acks are suppressed
    // while frozen or in reset so no rollback escapes an abandoned sequence.
    assign rollback_en      = en && !reset && (state_q == FLUSH);
    assign ROB_rollback_idx = held_idx_q;
    assign dispatch_stall   = (state_q != IDLE);
    assign busy             = (state_q != IDLE);
    assign br_ack           = (en && !reset) ? br_valid : '0;

endmodule

// File: tb/tb_rollback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rollback_ctrl
// Directed-vector bench for rollback_ctrl (NUM_ROB=32, NUM_BR=2, RECOVER_CYC=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_rollback_ctrl;

    logic            clock = 1'b0;
    logic            reset;
    logic            en;
    logic [1:0]      br_valid;
    logic [1:0]      br_mispredict;
    logic [1:0][4:0] br_rob_idx;
    logic [4:0]      rob_head_idx;
    logic            rollback_en;
    logic [4:0]      ROB_rollback_idx;
    logic            dispatch_stall;
    logic [1:0]      br_ack;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    rollback_ctrl #(
        .NUM_ROB     (32),
        .NUM_BR      (2),
        .RECOVER_CYC (2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .en               (en),
        .br_valid         (br_valid),
        .br_mispredict    (br_mispredict),
        .br_rob_idx       (br_rob_idx),
        .rob_head_idx     (rob_head_idx),
        .rollback_en      (rollback_en),
        .ROB_rollback_idx (ROB_rollback_idx),
        .dispatch_stall   (dispatch_stall),
        .br_ack           (br_ack),
        .busy             (busy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_br();
        br_valid      = 2'b00;
        br_mispredict = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b1; clr_br(); br_rob_idx = '0; rob_head_idx = 5'd0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; rob_head_idx = 5'd0;
        br_valid = 2'b11; br_mispredict = 2'b11; br_rob_idx[0] = 5'd3; br_rob_idx[1] = 5'd4;
        step(); step();
        vectors++; if (br_ack !== 2'b00) begin miscompares++; $display("FAIL rst_ack got=%b exp=00", br_ack); end
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL rst_rollback_en got=%b exp=0", rollback_en); end
        vectors++; if (ROB_rollback_idx !== 5'd0) begin miscompares++; $display("FAIL rst_idx got=%0d exp=0", ROB_rollback_idx); end
        vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%b exp=0", dispatch_stall); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        reset = 1'b0; clr_br();
        $display("txn reset: ack=%b rb=%b idx=%0d stall=%b busy=%b", br_ack, rollback_en, ROB_rollback_idx, dispatch_stall, busy);
    endtask

    task automatic test_basic();
        rob_head_idx = 5'd4; br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd10;
        #1;
        vectors++; if (br_ack !== 2'b01) begin miscompares++; $display("FAIL basic_ack got=%b exp=01", br_ack); end
        step(); clr_br();
        vectors++; if (rollback_en !== 1'b1) begin miscompares++; $display("FAIL basic_pulse got=%b exp=1", rollback_en); end
        vectors++; if (ROB_rollback_idx !== 5'd10) begin miscompares++; $display("FAIL basic_idx got=%0d exp=10", ROB_rollback_idx); end
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL basic_flush_stall got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL basic_pulse_end got=%b exp=0", rollback_en); end
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL basic_drain_stall got=%b exp=1", dispatch_stall); end
        rob_head_idx = 5'd10;
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL basic_rec1_stall got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL basic_rec2_stall got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL basic_idle_stall got=%b exp=0", dispatch_stall); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
        vectors++; if (ROB_rollback_idx !== 5'd10) begin miscompares++; $display("FAIL basic_held_idx got=%0d exp=10", ROB_rollback_idx); end
        $display("txn basic: head=10 idx=%0d stall=%b busy=%b", ROB_rollback_idx, dispatch_stall, busy);
    endtask

    task automatic test_oldest();
        do_reset();
        rob_head_idx = 5'd28; br_valid = 2'b11; br_mispredict = 2'b11;
        br_rob_idx[0] = 5'd2; br_rob_idx[1] = 5'd30;
        #1;
        vectors++; if (br_ack !== 2'b11) begin miscompares++; $display("FAIL oldest_ack got=%b exp=11", br_ack); end
        step(); clr_br();
        vectors++; if (rollback_en !== 1'b1) begin miscompares++; $display("FAIL oldest_pulse got=%b exp=1", rollback_en); end
        vectors++; if (ROB_rollback_idx !== 5'd30) begin miscompares++; $display("FAIL oldest_idx got=%0d exp=30", ROB_rollback_idx); end
        $display("txn oldest: head=28 idx=%0d", ROB_rollback_idx);
        // only br1 mispredicts; br0 is a correct resolution of an older branch
        do_reset();
        rob_head_idx = 5'd0; br_valid = 2'b11; br_mispredict = 2'b10;
        br_rob_idx[0] = 5'd20; br_rob_idx[1] = 5'd25;
        #1;
        vectors++; if (br_ack !== 2'b11) begin miscompares++; $display("FAIL mask_ack got=%b exp=11", br_ack); end
        step(); clr_br();
        vectors++; if (ROB_rollback_idx !== 5'd25) begin miscompares++; $display("FAIL mask_idx got=%0d exp=25", ROB_rollback_idx); end
        $display("txn mask: head=0 idx=%0d", ROB_rollback_idx);
    endtask

    task automatic test_replace();
        do_reset();
        rob_head_idx = 5'd8; br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd12;
        step(); clr_br();
        step();
        vectors++; if (ROB_rollback_idx !== 5'd12) begin miscompares++; $display("FAIL repl_first_idx got=%0d exp=12", ROB_rollback_idx); end
        br_valid = 2'b10; br_mispredict = 2'b10; br_rob_idx[1] = 5'd9;
        #1;
        vectors++; if (br_ack !== 2'b10) begin miscompares++; $display("FAIL repl_ack got=%b exp=10", br_ack); end
        step(); clr_br();
        vectors++; if (rollback_en !== 1'b1) begin miscompares++; $display("FAIL repl_pulse got=%b exp=1", rollback_en); end
        vectors++; if (ROB_rollback_idx !== 5'd9) begin miscompares++; $display("FAIL repl_idx got=%0d exp=9", ROB_rollback_idx); end
        // younger candidate during FLUSH is dropped
        br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd11;
        step(); clr_br();
        vectors++; if (ROB_rollback_idx !== 5'd9) begin miscompares++; $display("FAIL flush_drop_idx got=%0d exp=9", ROB_rollback_idx); end
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL flush_drop_pulse got=%b exp=0", rollback_en); end
        // younger candidate during DRAIN is dropped
        br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd15;
        #1;
        vectors++; if (br_ack !== 2'b01) begin miscompares++; $display("FAIL drop_ack got=%b exp=01", br_ack); end
        step(); clr_br();
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL drop_pulse got=%b exp=0", rollback_en); end
        vectors++; if (ROB_rollback_idx !== 5'd9) begin miscompares++; $display("FAIL drop_idx got=%0d exp=9", ROB_rollback_idx); end
        // equal-age candidate is dropped too
        br_valid = 2'b10; br_mispredict = 2'b10; br_rob_idx[1] = 5'd9;
        step(); clr_br();
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL equal_drop_pulse got=%b exp=0", rollback_en); end
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL equal_drop_stall got=%b exp=1", dispatch_stall); end
        $display("txn replace: held=%0d rb=%b stall=%b", ROB_rollback_idx, rollback_en, dispatch_stall);
    endtask

    task automatic test_wrap();
        do_reset();
        rob_head_idx = 5'd29; br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd31;
        step(); clr_br();
        vectors++; if (ROB_rollback_idx !== 5'd31) begin miscompares++; $display("FAIL wrap_idx got=%0d exp=31", ROB_rollback_idx); end
        step();
        rob_head_idx = 5'd30;
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL wrap_head30 got=%b exp=1", dispatch_stall); end
        rob_head_idx = 5'd31;
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL wrap_rec1 got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL wrap_rec2 got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL wrap_idle got=%b exp=0", dispatch_stall); end
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_stay_idle got=%b exp=0", busy); end
        $display("txn wrap: held=%0d stall=%b busy=%b", ROB_rollback_idx, dispatch_stall, busy);
    endtask

    task automatic test_age0();
        do_reset();
        rob_head_idx = 5'd7; br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd7;
        step(); clr_br();
        vectors++; if (rollback_en !== 1'b1) begin miscompares++; $display("FAIL age0_pulse got=%b exp=1", rollback_en); end
        vectors++; if (ROB_rollback_idx !== 5'd7) begin miscompares++; $display("FAIL age0_idx got=%0d exp=7", ROB_rollback_idx); end
        step(); step(); step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL age0_rec2 got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL age0_idle got=%b exp=0", dispatch_stall); end
        $display("txn age0: held=%0d stall=%b", ROB_rollback_idx, dispatch_stall);
    endtask

    task automatic test_reset_mid();
        do_reset();
        rob_head_idx = 5'd3; br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd20;
        step(); clr_br();
        step();
        // reset wins even with en low
        reset = 1'b1; en = 1'b0; br_valid = 2'b11; br_mispredict = 2'b11;
        #1;
        vectors++; if (br_ack !== 2'b00) begin miscompares++; $display("FAIL rstmid_ack got=%b exp=00", br_ack); end
        step();
        vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL rstmid_stall got=%b exp=0", dispatch_stall); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        vectors++; if (ROB_rollback_idx !== 5'd0) begin miscompares++; $display("FAIL rstmid_idx got=%0d exp=0", ROB_rollback_idx); end
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL rstmid_pulse got=%b exp=0", rollback_en); end
        reset = 1'b0; en = 1'b1; clr_br();
        step();
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL rstmid_after got=%b exp=0", rollback_en); end
        $display("txn reset_mid: rb=%b idx=%0d stall=%b busy=%b", rollback_en, ROB_rollback_idx, dispatch_stall, busy);
    endtask

    task automatic test_freeze();
        do_reset();
        rob_head_idx = 5'd3; br_valid = 2'b01; br_mispredict = 2'b01; br_rob_idx[0] = 5'd5;
        step(); clr_br();
        en = 1'b0;
        #1;
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL frz_pulse_gated got=%b exp=0", rollback_en); end
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL frz_flush_stall got=%b exp=1", dispatch_stall); end
        step();
        en = 1'b1;
        #1;
        vectors++; if (rollback_en !== 1'b1) begin miscompares++; $display("FAIL frz_pulse_resume got=%b exp=1", rollback_en); end
        step();
        rob_head_idx = 5'd5; en = 1'b0; br_valid = 2'b01;
        #1;
        vectors++; if (br_ack !== 2'b00) begin miscompares++; $display("FAIL frz_ack got=%b exp=00", br_ack); end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL frz_drain_%0d got=%b exp=1", i, dispatch_stall); end
        end
        clr_br(); en = 1'b1;
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL frz_rec1 got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (dispatch_stall !== 1'b1) begin miscompares++; $display("FAIL frz_rec2 got=%b exp=1", dispatch_stall); end
        step();
        vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL frz_idle got=%b exp=0", dispatch_stall); end
        $display("txn freeze: held=%0d stall=%b busy=%b", ROB_rollback_idx, dispatch_stall, busy);
    endtask

    task automatic test_no_mispredict();
        do_reset();
        rob_head_idx = 5'd1; br_valid = 2'b11; br_mispredict = 2'b00;
        br_rob_idx[0] = 5'd6; br_rob_idx[1] = 5'd9;
        #1;
        vectors++; if (br_ack !== 2'b11) begin miscompares++; $display("FAIL nomisp_ack got=%b exp=11", br_ack); end
        step(); clr_br();
        vectors++; if (rollback_en !== 1'b0) begin miscompares++; $display("FAIL nomisp_pulse got=%b exp=0", rollback_en); end
        vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL nomisp_stall got=%b exp=0", dispatch_stall); end
        $display("txn no_mispredict: rb=%b stall=%b", rollback_en, dispatch_stall);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; clr_br(); br_rob_idx = '0; rob_head_idx = 5'd0;
        test_reset();
        test_basic();
        test_oldest();
        test_replace();
        test_wrap();
        test_age0();
        test_reset_mid();
        test_freeze();
        test_no_mispredict();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rollback_ctrl.md
ROLLBACK_CTRL -- requirements
Module: rollback_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROB, 32, ROB entries (power of two).
REQ-002 SHALL have parameter NUM_BR, 2, branch-resolution requesters.
REQ-003 SHALL have parameter RECOVER_CYC, 2, post-drain recovery stall cycles (>=1).
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  global enable; low freezes all state.
REQ-007 SHALL have port br_valid  input  NUM_BR  branch resolved this cycle, per requester.
REQ-008 SHALL have port br_mispredict  input  NUM_BR  resolved branch mispredicted.
REQ-009 SHALL have port br_rob_idx  input  NUM_BR x log2(NUM_ROB)  ROB index of each branch.
REQ-010 SHALL have port rob_head_idx  input  log2(NUM_ROB)  current ROB head.
REQ-011 SHALL have port rollback_en  output  1  one-cycle rollback pulse to ROB.
REQ-012 SHALL have port ROB_rollback_idx  output  log2(NUM_ROB)  branch index to roll back to.
REQ-013 SHALL have port dispatch_stall  output  1  block dispatch.
REQ-014 SHALL have port br_ack  output  NUM_BR  request consumed this cycle.
REQ-015 SHALL have port busy  output  1  state != IDLE.

Function
REQ-016 Age of index i SHALL be (i - rob_head_idx) mod NUM_ROB, log2(NUM_ROB)-bit wrap arithmetic; smaller age = older.
REQ-017 Candidates SHALL be requesters with br_valid & br_mispredict; winner = oldest; equal ages -> lowest requester number.
REQ-018 br_ack SHALL be combinational, equal to br_valid for every requester in the cycle (correct, winning, or losing requests all consumed).
REQ-019 FSM states SHALL be IDLE, FLUSH, DRAIN, RECOVER.
REQ-020 IDLE: candidate present -> latch winner index into held_idx, go FLUSH next cycle.
REQ-021 FLUSH: rollback_en=1, ROB_rollback_idx=held_idx for exactly one cycle; next state DRAIN.
REQ-022 DRAIN: rollback_en=0; when rob_head_idx == held_idx load counter with RECOVER_CYC-1, go RECOVER.
REQ-023 RECOVER: counter decrements each cycle; at 0 go IDLE.
REQ-024 In DRAIN or RECOVER, a candidate older than held_idx (age relative to current head) SHALL replace held_idx and go FLUSH; younger or equal candidates SHALL be dropped.
REQ-025 In FLUSH, any new candidate SHALL be dropped (held branch squashes all younger work the same cycle; older cannot exist after prior arbitration plus drop rule - precondition enforced by bench).
REQ-026 dispatch_stall SHALL be 1 in FLUSH, DRAIN, RECOVER, and 0 in IDLE.
REQ-027 Outside FLUSH, ROB_rollback_idx SHALL hold held_idx; rollback_en SHALL be 0.
REQ-028 en=0: state, held_idx, counter frozen; rollback_en forced 0; br_ack forced 0; dispatch_stall reflects held state.
REQ-029 Head wrap: comparison uses modular age; held_idx=31, head 30->31 SHALL exit DRAIN.
REQ-030 Candidate with head already equal to its index (age 0) in IDLE SHALL still flush then pass DRAIN in one cycle.

Reset
REQ-031 reset SHALL take priority over en: state IDLE, held_idx 0, counter 0.
REQ-032 Outputs after reset: rollback_en 0, ROB_rollback_idx 0, dispatch_stall 0, busy 0; br_ack 0 while reset high.
REQ-033 reset asserted mid-FLUSH/DRAIN/RECOVER SHALL abandon the rollback with no further pulse.

Structure
REQ-034 State enum (ROLLBACK_STATE_t) and NUM_ROB/NUM_BR constants SHALL live in the shared ROB header package alongside ROB_t.
REQ-035 One sub-module SHALL exist: age_arbiter (combinational oldest-of-NUM_BR selector returning valid, winner index, winner ROB index).
REQ-036 All state SHALL be in one always_ff with `SD delays; next-state logic combinational.

Verification
REQ-037 head=4, br0 mispredict idx 10 -> cycle+1 rollback_en=1 idx 10; stall until head=10, then 2 RECOVER cycles, then IDLE.
REQ-038 head=28, br0 idx 2, br1 idx 30 same cycle -> winner idx 30 (age 2 < age 6); both acked.
REQ-039 In DRAIN held 12, head 8, br1 mispredict idx 9 -> second FLUSH idx 9; later br0 idx 15 dropped, no pulse.
REQ-040 held 31, head steps 29,30,31 -> RECOVER on head=31 cycle+1, IDLE after 2 cycles; stall low thereafter.
REQ-041 Reset asserted during DRAIN -> next cycle all outputs 0, IDLE; en=0 during DRAIN for 5 cycles with head=held -> no state change until en=1.
REQ-042 br_valid with br_mispredict=0 only -> br_ack=1, no rollback, dispatch_stall stays 0.
